// File: rtl/dmem_axi_bridge_pkg.sv
// rtl/dmem_axi_bridge_pkg.sv - shared types, AXI constants and strobe-to-size helper
// Purpose: FSM state encoding for the data-memory bridge, fixed AXI4 field
// values and the mapping from byte strobes to AXI transfer size.
// Ports: none (package).
package dmem_axi_bridge_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_ADDR,
    ST_RD_DATA,
    ST_WR,
    ST_WR_RESP,
    ST_DONE
  } state_t;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [7:0] AXI_LEN_SINGLE = 8'd0;
  localparam logic [2:0] AXI_SIZE_B     = 3'd0;
  localparam logic [2:0] AXI_SIZE_H     = 3'd1;
  localparam logic [2:0] AXI_SIZE_W     = 3'd2;

  // Strobes arrive already lane-aligned from the core, so only the
  // population pattern matters. Unexpected patterns fall back to a word
  // transfer; wstrb still qualifies which bytes land.
  function automatic logic [2:0] strb_to_size(input logic [3:0] strb);
    case (strb)
      4'b1111:                            return AXI_SIZE_W;
      4'b0011, 4'b1100:                   return AXI_SIZE_H;
      4'b0001, 4'b0010, 4'b0100, 4'b1000: return AXI_SIZE_B;
      default:                            return AXI_SIZE_W;
    endcase
  endfunction

endpackage

// File: rtl/dmem_axi_bridge.sv
// rtl/dmem_axi_bridge.sv - core data-memory port to single-beat AXI4 bridge
// Purpose: turns each data request from the core into one AXI4 read or write
// transaction, stalls the pipeline until it completes and holds the result
// until the memory stage advances.
// Ports:
//   clk, rst            - clock, synchronous active-high reset
//   mem_en/addr/wen/wdata, mem_rdata, d_stall - core data request port
//   longest_stall       - OR of all pipeline stalls (low = M advances)
//   ar*/r*/aw*/w*/b*    - AXI4 master channels
module dmem_axi_bridge
  import dmem_axi_bridge_pkg::*;
#(
  parameter logic [3:0] AXI_ID = 4'd1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_en,
  input  logic [31:0] mem_addr,
  input  logic [3:0]  mem_wen,
  input  logic [31:0] mem_wdata,
  output logic [31:0] mem_rdata,
  output logic        d_stall,
  input  logic        longest_stall,
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic        arvalid,
  input  logic        arready,
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready,
  output logic [3:0]  awid,
  output logic [31:0] awaddr,
  output logic [7:0]  awlen,
  output logic [2:0]  awsize,
  output logic [1:0]  awburst,
  output logic        awvalid,
  input  logic        awready,
  output logic [3:0]  wid,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wlast,
  output logic        wvalid,
  input  logic        wready,
  input  logic [3:0]  bid,
  input  logic [1:0]  bresp,
  input  logic        bvalid,
  output logic        bready
);

  state_t      state, next_state;
  logic [31:0] addr_q, wdata_q;
  logic [3:0]  wen_q;
  logic [2:0]  size_q;
  logic        aw_ok, w_ok;

  logic ar_hs, r_hs, aw_hs, w_hs, b_hs, aw_done, w_done;
  assign ar_hs   = arvalid & arready;
  assign r_hs    = rready & rvalid;
  assign aw_hs   = awvalid & awready;
  assign w_hs    = wvalid & wready;
  assign b_hs    = bready & bvalid;
  // Each write channel counts as done once its handshake has happened,
  // either earlier (sticky flag) or in the current cycle.
  assign aw_done = aw_ok | aw_hs;
  assign w_done  = w_ok | w_hs;

  // Response status and IDs are intentionally not acted upon.
  logic unused_resp;
  assign unused_resp = ^{rid, rresp, rlast, bid, bresp};

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= next_state;
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:    if (mem_en) next_state = (mem_wen == 4'b0000) ? ST_RD_ADDR : ST_WR;
      ST_RD_ADDR: if (ar_hs) next_state = ST_RD_DATA;
      ST_RD_DATA: if (r_hs) next_state = ST_DONE;
      ST_WR:      if (aw_done && w_done) next_state = ST_WR_RESP;
      ST_WR_RESP: if (b_hs) next_state = ST_DONE;
      // Result is held here until the pipeline actually moves on, so a
      // request still presented during an unrelated stall is not reissued.
      ST_DONE:    if (!longest_stall) next_state = ST_IDLE;
      default:    next_state = ST_IDLE;
    endcase
  end

  // Combinational outputs
  always_comb begin
    d_stall = mem_en && (state != ST_DONE);
    arid    = AXI_ID;
    araddr  = {addr_q[31:2], 2'b00};
    arlen   = AXI_LEN_SINGLE;
    arsize  = AXI_SIZE_W;
    arburst = AXI_BURST_INCR;
    awid    = AXI_ID;
    awaddr  = addr_q;
    awlen   = AXI_LEN_SINGLE;
    awsize  = size_q;
    awburst = AXI_BURST_INCR;
    wid     = AXI_ID;
    wdata   = wdata_q;
    wstrb   = wen_q;
    wlast   = 1'b1;
  end

  // Registered handshake outputs and request capture. Valids/readies are
  // derived from next_state so they are flops aligned with the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      arvalid   <= 1'b0;
      rready    <= 1'b0;
      awvalid   <= 1'b0;
      wvalid    <= 1'b0;
      bready    <= 1'b0;
      aw_ok     <= 1'b0;
      w_ok      <= 1'b0;
      addr_q    <= '0;
      wen_q     <= '0;
      wdata_q   <= '0;
      size_q    <= '0;
      mem_rdata <= '0;
    end else begin
      arvalid <= (next_state == ST_RD_ADDR);
      rready  <= (next_state == ST_RD_DATA);
      bready  <= (next_state == ST_WR_RESP);
      // Drop each write valid right after its own handshake; the other may
      // still be waiting.
      awvalid <= (next_state == ST_WR) && !((state == ST_WR) && aw_done);
      wvalid  <= (next_state == ST_WR) && !((state == ST_WR) && w_done);

      if (state == ST_IDLE && mem_en) begin
        addr_q  <= mem_addr;
        wen_q   <= mem_wen;
        wdata_q <= mem_wdata;
        size_q  <= strb_to_size(mem_wen);
        aw_ok   <= 1'b0;
        w_ok    <= 1'b0;
      end else if (state == ST_WR) begin
        aw_ok <= aw_done;
        w_ok  <= w_done;
      end

      if (r_hs) mem_rdata <= rdata;
    end
  end

endmodule

// File: tb/tb_dmem_axi_bridge.sv
// tb/tb_dmem_axi_bridge.sv - self-checking bench for dmem_axi_bridge
module tb_dmem_axi_bridge;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, mem_en, d_stall, longest_stall, i_stall;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wen;
  logic [3:0]  arid, rid, awid, wid, bid;
  logic [31:0] araddr, rdata, awaddr, wdata;
  logic [7:0]  arlen, awlen;
  logic [2:0]  arsize, awsize;
  logic [1:0]  arburst, rresp, awburst, bresp;
  logic        arvalid, arready, rlast, rvalid, rready;
  logic        awvalid, awready, wvalid, wready, wlast, bvalid, bready;
  logic [3:0]  wstrb;

  assign longest_stall = d_stall | i_stall;

  dmem_axi_bridge dut (
    .clk(clk), .rst(rst), .mem_en(mem_en), .mem_addr(mem_addr), .mem_wen(mem_wen),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .d_stall(d_stall),
    .longest_stall(longest_stall),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // AXI size from the number of bytes written.
  function automatic logic [2:0] exp_size(input logic [3:0] s);
    int n;
    n = $countones(s);
    if (n == 1) return 3'd0;
    if (n == 2) return 3'd1;
    return 3'd2;
  endfunction

  // Slave configuration and state
  int          ar_delay = 0, r_delay = 0, aw_delay = 0, w_delay = 0, b_delay = 0;
  logic [31:0] rd_value = 32'h0;
  logic [1:0]  b_resp_cfg = 2'b00;
  int          ar_wait = 0, r_wait = 0, aw_wait = 0, w_wait = 0, b_wait = 0;
  bit          r_pend = 0, aw_seen = 0, w_seen = 0, b_pend = 0;

  // Current request as issued by the core
  logic [31:0] req_addr = 32'h0, req_wdata = 32'h0;
  logic [3:0]  req_wen = 4'h0;

  // Request-level model
  bit          started = 0, complete = 0, after_reset = 0;
  bit          ar_pend_prev = 0, aw_pend_prev = 0, w_pend_prev = 0;
  logic [31:0] exp_rdata = 32'h0;

  // Observations for directed checks
  int          ar_hs_cnt = 0, aw_cyc = 0, w_cyc = 0, stall_hi_cnt = 0;
  logic [31:0] last_araddr = 32'h0;
  logic [2:0]  last_arsize = 3'd7, last_awsize = 3'd7;
  logic [3:0]  last_wstrb = 4'h0;

  // Slave drive: readies/valids for each cycle, set just after the edge.
  initial begin
    arready = 0; rvalid = 0; rdata = 0; rid = 0; rresp = 0; rlast = 0;
    awready = 0; wready = 0; bvalid = 0; bid = 0; bresp = 0;
    forever begin
      @(posedge clk);
      #1;
      arready = arvalid && (ar_wait >= ar_delay);
      rvalid  = r_pend && (r_wait >= r_delay);
      rdata   = rvalid ? rd_value : 32'h0;
      rlast   = rvalid;
      rid     = 4'd1;
      rresp   = 2'b00;
      awready = awvalid && (aw_wait >= aw_delay);
      wready  = wvalid && (w_wait >= w_delay);
      bvalid  = b_pend && (b_wait >= b_delay);
      bresp   = bvalid ? b_resp_cfg : 2'b00;
      bid     = 4'd1;
    end
  end

  // Compare against the model, then advance model and slave state.
  task monitor_loop;
    forever begin
      @(negedge clk);
      if (started) begin
        check("d_stall", 32'(mem_en && !complete), 32'(1'b1 && d_stall));
        check("mem_rdata", mem_rdata, exp_rdata);
        if (after_reset)
          check("handshake_after_reset", 32'({arvalid, rready, awvalid, wvalid, bready}), 32'd0);
        if (complete)
          check("no_issue_while_done", 32'({arvalid, awvalid, wvalid}), 32'd0);
        if (ar_pend_prev) check("arvalid_held", 32'(arvalid), 32'd1);
        if (aw_pend_prev) check("awvalid_held", 32'(awvalid), 32'd1);
        if (w_pend_prev)  check("wvalid_held", 32'(wvalid), 32'd1);
        if (arvalid) begin
          check("ar_for_read", 32'(req_wen == 4'd0), 32'd1);
          check("araddr", araddr, {req_addr[31:2], 2'b00});
          check("ar_fields", 32'({arid, arlen, arsize, arburst}),
                32'({4'd1, 8'd0, 3'd2, 2'b01}));
          last_araddr = araddr;
          last_arsize = arsize;
        end
        if (awvalid) begin
          check("aw_for_write", 32'(req_wen != 4'd0), 32'd1);
          check("awaddr", awaddr, req_addr);
          check("aw_fields", 32'({awid, awlen, awsize, awburst}),
                32'({4'd1, 8'd0, exp_size(req_wen), 2'b01}));
          last_awsize = awsize;
          aw_cyc++;
        end
        if (wvalid) begin
          check("w_fields", 32'({wid, wstrb, wlast}), 32'({4'd1, req_wen, 1'b1}));
          check("wdata", wdata, req_wdata);
          last_wstrb = wstrb;
          w_cyc++;
        end
        if (d_stall) stall_hi_cnt++;
      end

      if (rst) begin
        started = 1; complete = 0; after_reset = 1; exp_rdata = 32'h0;
        ar_pend_prev = 0; aw_pend_prev = 0; w_pend_prev = 0;
        ar_wait = 0; r_wait = 0; aw_wait = 0; w_wait = 0; b_wait = 0;
        r_pend = 0; aw_seen = 0; w_seen = 0; b_pend = 0;
      end else begin
        after_reset = 0;
        ar_pend_prev = arvalid && !arready;
        aw_pend_prev = awvalid && !awready;
        w_pend_prev  = wvalid && !wready;
        if (complete && !longest_stall) complete = 0;
        if (rvalid && rready) begin complete = 1; exp_rdata = rd_value; end
        if (bvalid && bready) complete = 1;

        if (r_pend) begin
          if (rvalid && rready) r_pend = 0; else r_wait++;
        end
        if (arvalid) begin
          if (arready) begin ar_hs_cnt++; r_pend = 1; r_wait = 0; ar_wait = 0; end
          else ar_wait++;
        end
        if (b_pend) begin
          if (bvalid && bready) b_pend = 0; else b_wait++;
        end
        if (awvalid) begin
          if (awready) begin aw_seen = 1; aw_wait = 0; end else aw_wait++;
        end
        if (wvalid) begin
          if (wready) begin w_seen = 1; w_wait = 0; end else w_wait++;
        end
        if (aw_seen && w_seen) begin b_pend = 1; b_wait = 0; aw_seen = 0; w_seen = 0; end
      end
    end
  endtask

  // Present one request; returns at the start of the cycle after M advanced.
  task automatic run_req(input logic [31:0] a, input logic [3:0] wen, input logic [31:0] wd,
                         input int hold, output int stall_cyc);
    bit fell;
    fell = 0;
    mem_en = 1; mem_addr = a; mem_wen = wen; mem_wdata = wd;
    req_addr = a; req_wen = wen; req_wdata = wd;
    stall_cyc = 0;
    for (int i = 0; i < 60 && !fell; i++) begin
      @(negedge clk);
      if (d_stall) stall_cyc++; else fell = 1;
    end
    check("request_completes", 32'(fell), 32'd1);
    repeat (hold) @(posedge clk);
    if (hold > 0) begin #1; i_stall = 0; end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int st, st2, n0, s0, a0, w0;
    bit seen;
    rst = 1; mem_en = 0; mem_addr = 0; mem_wen = 0; mem_wdata = 0; i_stall = 0;
    fork
      monitor_loop();
    join_none
    repeat (3) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    check("reset_handshakes", 32'({arvalid, rready, awvalid, wvalid, bready}), 32'd0);
    check("reset_rdata", mem_rdata, 32'h0);
    check("reset_stall", 32'(d_stall), 32'd0);
    repeat (3) @(negedge clk);
    check("idle_no_activity", 32'(ar_hs_cnt), 32'd0);
    @(posedge clk);
    #1;

    // Zero-wait read
    rd_value = 32'hDEADBEEF;
    run_req(32'h1000_0006, 4'b0000, 32'h0, 0, st);
    mem_en = 0;
    check("rd_stall_cycles", 32'(st), 32'd3);
    check("rd_araddr", last_araddr, 32'h1000_0004);
    check("rd_arsize", 32'(last_arsize), 32'd2);
    check("rd_data", mem_rdata, 32'hDEADBEEF);

    // Byte write, awready late by 3 cycles, wready immediate
    @(posedge clk); #1;
    aw_delay = 3; a0 = aw_cyc; w0 = w_cyc;
    run_req(32'h2000_0002, 4'b0100, 32'h00AB_0000, 0, st);
    mem_en = 0; aw_delay = 0;
    check("bw_stall_cycles", 32'(st), 32'd6);
    check("bw_awvalid_cycles", 32'(aw_cyc - a0), 32'd4);
    check("bw_wvalid_cycles", 32'(w_cyc - w0), 32'd1);
    check("bw_awsize", 32'(last_awsize), 32'd0);
    check("bw_wstrb", 32'(last_wstrb), 32'b0100);
    check("bw_rdata_kept", mem_rdata, 32'hDEADBEEF);

    // Read completing under an i-fetch stall held 5 more cycles
    @(posedge clk); #1;
    i_stall = 1; rd_value = 32'h1234_5678; n0 = ar_hs_cnt; s0 = stall_hi_cnt;
    run_req(32'h1000_0100, 4'b0000, 32'h0, 5, st);
    mem_en = 0;
    check("held_stall_cycles", 32'(st), 32'd3);
    check("held_one_ar", 32'(ar_hs_cnt - n0), 32'd1);
    check("held_stall_total", 32'(stall_hi_cnt - s0), 32'd3);
    check("held_rdata", mem_rdata, 32'h1234_5678);

    // Back-to-back read then full-word write
    @(posedge clk); #1;
    rd_value = 32'hCAFE_F00D;
    run_req(32'h2000_0010, 4'b0000, 32'h0, 0, st);
    run_req(32'h2000_0020, 4'b1111, 32'h1122_3344, 0, st2);
    mem_en = 0;
    check("b2b_rd_stall", 32'(st), 32'd3);
    check("b2b_wr_stall", 32'(st2), 32'd3);
    check("b2b_awsize", 32'(last_awsize), 32'd2);
    check("b2b_rdata_kept", mem_rdata, 32'hCAFE_F00D);

    // Halfword write with SLVERR response
    @(posedge clk); #1;
    b_resp_cfg = 2'b10;
    run_req(32'h3000_0002, 4'b1100, 32'hBEEF_0000, 0, st);
    mem_en = 0; b_resp_cfg = 2'b00;
    check("hw_stall_cycles", 32'(st), 32'd3);
    check("hw_awsize", 32'(last_awsize), 32'd1);
    check("hw_wstrb", 32'(last_wstrb), 32'b1100);

    // Reset during RD_DATA
    @(posedge clk); #1;
    r_delay = 5;
    mem_en = 1; mem_addr = 32'h4000_0000; mem_wen = 4'b0000; mem_wdata = 32'h0;
    req_addr = 32'h4000_0000; req_wen = 4'b0000; req_wdata = 32'h0;
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (rready) seen = 1;
    end
    check("rst_reached_rd_data", 32'(seen), 32'd1);
    @(posedge clk); #1;
    rst = 1; mem_en = 0;
    @(posedge clk); #1;
    rst = 0;
    @(negedge clk);
    check("midrst_handshakes", 32'({arvalid, rready, awvalid, wvalid, bready}), 32'd0);
    check("midrst_rdata", mem_rdata, 32'h0);
    check("midrst_stall", 32'(d_stall), 32'd0);
    @(posedge clk); #1;
    r_delay = 0; rd_value = 32'h55AA_55AA;
    run_req(32'h4000_0008, 4'b0000, 32'h0, 0, st);
    mem_en = 0;
    check("post_rst_stall", 32'(st), 32'd3);
    check("post_rst_rdata", mem_rdata, 32'h55AA_55AA);

    n0 = ar_hs_cnt;
    repeat (5) @(negedge clk);
    check("final_idle", 32'(ar_hs_cnt - n0), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
